// File: rtl/video_timing_checker.sv
// Receive-side video timing checker: measures hsync/vsync/de geometry
// each frame and tracks lock and error count against the expected mode.
module video_timing_checker #(
  parameter int EXP_H_TOTAL  = 2200,
  parameter int EXP_V_TOTAL  = 1125,
  parameter int EXP_H_ACTIVE = 1920,
  parameter int EXP_V_ACTIVE = 1080,
  parameter int CNT_W        = 12,
  parameter int LOCK_FRAMES  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hsync,
  input  logic             vsync,
  input  logic             de,
  output logic [CNT_W-1:0] hTotal,
  output logic [CNT_W-1:0] vTotal,
  output logic [CNT_W-1:0] hActive,
  output logic [CNT_W-1:0] vActive,
  output logic             measValid,
  output logic             locked,
  output logic [7:0]       errCnt
);

  localparam logic [CNT_W-1:0] CMAX = '1;
  localparam logic [CNT_W-1:0] E_HT = CNT_W'(EXP_H_TOTAL);
  localparam logic [CNT_W-1:0] E_VT = CNT_W'(EXP_V_TOTAL);
  localparam logic [CNT_W-1:0] E_HA = CNT_W'(EXP_H_ACTIVE);
  localparam logic [CNT_W-1:0] E_VA = CNT_W'(EXP_V_ACTIVE);
  localparam int MW = $clog2(LOCK_FRAMES + 1);
  localparam logic [MW-1:0] LOCK_N = MW'(LOCK_FRAMES);

  typedef enum logic [1:0] {
    IDLE,
    MEAS,
    LOCKED
  } state_t;

  state_t state, state_n;

  logic hs_q, vs_q, de_q;
  logic hs_p, vs_p, de_p;
  logic hs_rise, vs_rise;
  logic de_rise, de_fall;

  logic [CNT_W-1:0] pix, lines;
  logic [CNT_W-1:0] run, act;
  logic [CNT_W-1:0] first_len, first_run;
  logic have_len, have_run, incons;

  logic [CNT_W-1:0] cur_len, cur_run;
  logic [CNT_W-1:0] cur_lines, cur_act;
  logic len_bad, run_bad;
  logic frame_ok, timeout;

  logic [MW-1:0] match_cnt, match_inc;
  logic report, hit, miss, tmo;

  assign hs_rise = hs_q & ~hs_p;
  assign vs_rise = vs_q & ~vs_p;
  assign de_rise = de_q & ~de_p;
  assign de_fall = ~de_q & de_p;

  // Events coincident with a vsync rise belong to the frame that ends.
  assign len_bad = hs_rise & have_len
                 & (pix != first_len);
  assign run_bad = de_fall & have_run
                 & (run != first_run);

  assign cur_len = have_len ? first_len
                 : (hs_rise ? pix : '0);
  assign cur_run = have_run ? first_run
                 : (de_fall ? run : '0);
  assign cur_lines = (hs_rise && lines != CMAX)
                   ? lines + 1'b1 : lines;
  assign cur_act = (de_rise && act != CMAX)
                 ? act + 1'b1 : act;

  assign frame_ok = (cur_len == E_HT)
                  & (cur_lines == E_VT)
                  & (cur_run == E_HA)
                  & (cur_act == E_VA)
                  & ~(incons | len_bad | run_bad);

  assign timeout = (pix == CMAX) | (lines == CMAX);

  assign match_inc = (match_cnt == LOCK_N)
                   ? LOCK_N : match_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_q <= 1'b0;
      vs_q <= 1'b0;
      de_q <= 1'b0;
      hs_p <= 1'b0;
      vs_p <= 1'b0;
      de_p <= 1'b0;
    end else begin
      hs_q <= hsync;
      vs_q <= vsync;
      de_q <= de;
      hs_p <= hs_q;
      vs_p <= vs_q;
      de_p <= de_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix       <= '0;
      run       <= '0;
      lines     <= '0;
      act       <= '0;
      first_len <= '0;
      first_run <= '0;
      have_len  <= 1'b0;
      have_run  <= 1'b0;
      incons    <= 1'b0;
    end else begin
      if (hs_rise) pix <= CNT_W'(1);
      else if (pix != CMAX) pix <= pix + 1'b1;

      if (de_rise) run <= CNT_W'(1);
      else if (de_q && run != CMAX) run <= run + 1'b1;

      if (vs_rise) begin
        lines     <= '0;
        act       <= '0;
        first_len <= '0;
        first_run <= '0;
        have_len  <= 1'b0;
        have_run  <= 1'b0;
        incons    <= 1'b0;
      end else begin
        lines <= cur_lines;
        act   <= cur_act;
        if (len_bad | run_bad) incons <= 1'b1;
        if (hs_rise && !have_len) begin
          first_len <= pix;
          have_len  <= 1'b1;
        end
        if (de_fall && !have_run) begin
          first_run <= run;
          have_run  <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_n = state;
    report  = 1'b0;
    hit     = 1'b0;
    miss    = 1'b0;
    tmo     = 1'b0;
    unique case (state)
      IDLE: if (vs_rise) state_n = MEAS;
      MEAS, LOCKED: begin
        if (timeout) begin
          tmo     = 1'b1;
          state_n = IDLE;
        end else if (vs_rise) begin
          report = 1'b1;
          if (frame_ok) begin
            hit = 1'b1;
            if (match_inc == LOCK_N)
              state_n = LOCKED;
          end else begin
            miss    = 1'b1;
            state_n = MEAS;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      match_cnt <= '0;
      errCnt    <= '0;
      measValid <= 1'b0;
      hTotal    <= '0;
      vTotal    <= '0;
      hActive   <= '0;
      vActive   <= '0;
    end else begin
      state     <= state_n;
      measValid <= report;
      if (report) begin
        hTotal  <= cur_len;
        vTotal  <= cur_lines;
        hActive <= cur_run;
        vActive <= cur_act;
      end
      if (tmo | miss) match_cnt <= '0;
      else if (hit) match_cnt <= match_inc;
      if ((tmo | miss) && errCnt != 8'hFF)
        errCnt <= errCnt + 8'd1;
    end
  end

  assign locked = (state == LOCKED);

endmodule
